// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline.
// Resolves what forwarding cannot: load-use stalls, taken-branch flushes and
// data-memory wait freezes (with timeout abort).
// Optional: define HAZARD_PERF_CNT_EN to add the stallcycles perf counter port.
module hazard_stall_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT       = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        idexmemrd,
  input  logic [4:0]  idexrt,
  input  logic [4:0]  ifidrs,
  input  logic [4:0]  ifidrt,
  input  logic [31:0] ifidins,
  input  logic        branchtaken,
  input  logic        dmemreq,
  input  logic        dmemready,
  output logic        pcwrite,
  output logic        ifidwrite,
  output logic        idexbubble,
  output logic        ifidflush,
  output logic        idexflush,
  output logic        freeze,
  output logic        memerr,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] stallcycles,
`endif
  output logic [1:0]  stallstate
);

  localparam logic [1:0] S_RUN     = 2'b00;
  localparam logic [1:0] S_LDSTALL = 2'b01;
  localparam logic [1:0] S_MEMWAIT = 2'b10;

  localparam logic [3:0] LD_INIT = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [7:0] TMO     = 8'(MEM_TIMEOUT);

  logic [1:0] state, state_n;
  logic [1:0] sv_state, sv_state_n;   // state interrupted by a memory wait
  logic [3:0] cnt, cnt_n;             // remaining LDSTALL cycles
  logic [3:0] sv_cnt, sv_cnt_n;       // LDSTALL count held across a memory wait
  logic [7:0] wcnt, wcnt_n;           // memory wait cycle counter
  logic       memerr_n;

  logic [5:0] opcode;
  logic       rtused, hazard, memwait;
  logic       unused_ins;

  assign opcode     = ifidins[31:26];
  assign unused_ins = ^ifidins[25:0];
  assign rtused     = (opcode == 6'h00) || (opcode == 6'h2b) ||
                      (opcode == 6'h04) || (opcode == 6'h05);
  assign hazard     = idexmemrd && (idexrt != 5'd0) &&
                      ((idexrt == ifidrs) || (rtused && (idexrt == ifidrt)));
  assign memwait    = dmemreq && !dmemready;
  assign stallstate = state;

  // Output decode and next-state/counter update; reset overrides outputs last.
  always_comb begin
    pcwrite    = 1'b1;
    ifidwrite  = 1'b1;
    idexbubble = 1'b0;
    ifidflush  = 1'b0;
    idexflush  = 1'b0;
    freeze     = 1'b0;
    state_n    = state;
    sv_state_n = sv_state;
    cnt_n      = cnt;
    sv_cnt_n   = sv_cnt;
    wcnt_n     = wcnt;
    memerr_n   = 1'b0;
    case (state)
      S_RUN, S_LDSTALL: begin
        if (memwait) begin
          freeze     = 1'b1;
          pcwrite    = 1'b0;
          ifidwrite  = 1'b0;
          state_n    = S_MEMWAIT;
          sv_state_n = state;
          sv_cnt_n   = cnt;
          wcnt_n     = 8'd1;
        end else if (state == S_RUN) begin
          if (branchtaken) begin
            // Branch flush wins over load-use; the stalled instruction is wrong-path.
            ifidflush = 1'b1;
            idexflush = 1'b1;
          end else if (hazard) begin
            pcwrite    = 1'b0;
            ifidwrite  = 1'b0;
            idexbubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_n = S_LDSTALL;
              cnt_n   = LD_INIT;
            end
          end
        end else begin
          pcwrite    = 1'b0;
          ifidwrite  = 1'b0;
          idexbubble = 1'b1;
          if (cnt <= 4'd1) begin
            state_n = S_RUN;
            cnt_n   = 4'd0;
          end else begin
            cnt_n = cnt - 4'd1;
          end
        end
      end
      S_MEMWAIT: begin
        if (dmemready) begin
          // Ack cycle: pipeline unfreezes and shows the interrupted state's
          // outputs; the interrupted state and its count are restored as-is.
          state_n = sv_state;
          cnt_n   = sv_cnt;
          if (sv_state == S_LDSTALL) begin
            pcwrite    = 1'b0;
            ifidwrite  = 1'b0;
            idexbubble = 1'b1;
          end else if (branchtaken) begin
            ifidflush = 1'b1;
            idexflush = 1'b1;
          end else if (hazard) begin
            pcwrite    = 1'b0;
            ifidwrite  = 1'b0;
            idexbubble = 1'b1;
          end
        end else begin
          freeze    = 1'b1;
          pcwrite   = 1'b0;
          ifidwrite = 1'b0;
          if (wcnt >= TMO) begin
            state_n    = S_RUN;
            sv_state_n = S_RUN;
            cnt_n      = 4'd0;
            sv_cnt_n   = 4'd0;
            wcnt_n     = 8'd0;
            memerr_n   = 1'b1;
          end else begin
            wcnt_n = wcnt + 8'd1;
          end
        end
      end
      default: begin
        state_n = S_RUN;
        cnt_n   = 4'd0;
      end
    endcase
    if (rst) begin
      pcwrite    = 1'b0;
      ifidwrite  = 1'b0;
      idexbubble = 1'b1;
      ifidflush  = 1'b0;
      idexflush  = 1'b0;
      freeze     = 1'b0;
    end
  end

  // State, counters, saved context and the memerr pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RUN;
      sv_state <= S_RUN;
      cnt      <= 4'd0;
      sv_cnt   <= 4'd0;
      wcnt     <= 8'd0;
      memerr   <= 1'b0;
    end else begin
      state    <= state_n;
      sv_state <= sv_state_n;
      cnt      <= cnt_n;
      sv_cnt   <= sv_cnt_n;
      wcnt     <= wcnt_n;
      memerr   <= memerr_n;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk) begin
    if (rst)
      stallcycles <= 32'd0;
    else if (!pcwrite && (stallcycles != 32'hFFFF_FFFF))
      stallcycles <= stallcycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: one instance with LOAD_STALL_CYCLES=1,
// MEM_TIMEOUT=255 (u1) and one with LOAD_STALL_CYCLES=3, MEM_TIMEOUT=8 (u3),
// driven by shared stimulus.
module tb_hazard_stall_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        idexmemrd;
  logic [4:0]  idexrt, ifidrs, ifidrt;
  logic [31:0] ifidins;
  logic        branchtaken, dmemreq, dmemready;

  logic pw1, ifw1, bub1, iff1, ief1, frz1, err1;
  logic pw3, ifw3, bub3, iff3, ief3, frz3, err3;
  logic [1:0] st1, st3;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] sc1, sc3;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(255)) u1 (
    .clk(clk), .rst(rst), .idexmemrd(idexmemrd), .idexrt(idexrt),
    .ifidrs(ifidrs), .ifidrt(ifidrt), .ifidins(ifidins),
    .branchtaken(branchtaken), .dmemreq(dmemreq), .dmemready(dmemready),
    .pcwrite(pw1), .ifidwrite(ifw1), .idexbubble(bub1), .ifidflush(iff1),
    .idexflush(ief1), .freeze(frz1), .memerr(err1),
`ifdef HAZARD_PERF_CNT_EN
    .stallcycles(sc1),
`endif
    .stallstate(st1));

  hazard_stall_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(8)) u3 (
    .clk(clk), .rst(rst), .idexmemrd(idexmemrd), .idexrt(idexrt),
    .ifidrs(ifidrs), .ifidrt(ifidrt), .ifidins(ifidins),
    .branchtaken(branchtaken), .dmemreq(dmemreq), .dmemready(dmemready),
    .pcwrite(pw3), .ifidwrite(ifw3), .idexbubble(bub3), .ifidflush(iff3),
    .idexflush(ief3), .freeze(frz3), .memerr(err3),
`ifdef HAZARD_PERF_CNT_EN
    .stallcycles(sc3),
`endif
    .stallstate(st3));

  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task tick;
    @(posedge clk);
    #1;
  endtask

  task set_id(input logic mr, input logic [4:0] rt_ex, input logic [5:0] op,
              input logic [4:0] rs, input logic [4:0] rt);
    idexmemrd = mr;
    idexrt    = rt_ex;
    ifidrs    = rs;
    ifidrt    = rt;
    ifidins   = {op, rs, rt, 16'h0000};
  endtask

  initial begin
    rst = 1'b1;
    branchtaken = 1'b0;
    dmemreq = 1'b0;
    dmemready = 1'b0;
    set_id(1'b0, 5'd0, 6'h00, 5'd0, 5'd0);
    tick; tick;
    // reset state
    chk("rst_pcwrite", pw1, 0);
    chk("rst_ifidwrite", ifw1, 0);
    chk("rst_bubble", bub1, 1);
    chk("rst_ifidflush", iff1, 0);
    chk("rst_freeze", frz1, 0);
    chk("rst_memerr", err1, 0);
    chk("rst_state1", st1, 0);
    chk("rst_state3", st3, 0);

    rst = 1'b0;
    #1;
    chk("dflt_pcwrite", pw1, 1);
    chk("dflt_ifidwrite", ifw1, 1);
    chk("dflt_bubble", bub1, 0);

    // load-use on rs: single stall (u1), three-cycle stall (u3)
    set_id(1'b1, 5'd5, 6'h00, 5'd5, 5'd7);
    #1;
    chk("lu_pcwrite1", pw1, 0);
    chk("lu_ifidwrite1", ifw1, 0);
    chk("lu_bubble1", bub1, 1);
    chk("lu_state1", st1, 0);
    chk("lu_pcwrite3_c0", pw3, 0);
    tick;
    set_id(1'b0, 5'd0, 6'h00, 5'd0, 5'd0);
    #1;
    chk("lu_after_pcwrite1", pw1, 1);
    chk("lu_after_bubble1", bub1, 0);
    chk("lu_after_state1", st1, 0);
    chk("lu_state3_c1", st3, 1);
    chk("lu_pcwrite3_c1", pw3, 0);
    tick;
    chk("lu_state3_c2", st3, 1);
    chk("lu_pcwrite3_c2", pw3, 0);
    tick;
    chk("lu_state3_c3", st3, 0);
    chk("lu_pcwrite3_c3", pw3, 1);

    // rtused decode and r0 exclusion
    set_id(1'b1, 5'd5, 6'h08, 5'd2, 5'd5);
    #1;
    chk("addi_rt_nostall", pw1, 1);
    set_id(1'b1, 5'd5, 6'h2b, 5'd2, 5'd5);
    #1;
    chk("sw_rt_stall", pw1, 0);
    set_id(1'b1, 5'd5, 6'h04, 5'd2, 5'd5);
    #1;
    chk("beq_rt_stall", bub1, 1);
    set_id(1'b1, 5'd0, 6'h00, 5'd0, 5'd0);
    #1;
    chk("r0_nostall", pw1, 1);
    set_id(1'b0, 5'd0, 6'h00, 5'd0, 5'd0);
    #1;

    // branch flush beats a simultaneous load-use hazard
    branchtaken = 1'b1;
    set_id(1'b1, 5'd5, 6'h00, 5'd5, 5'd7);
    #1;
    chk("br_ifidflush", iff1, 1);
    chk("br_idexflush", ief1, 1);
    chk("br_pcwrite", pw1, 1);
    chk("br_bubble", bub1, 0);
    chk("br_ifidflush3", iff3, 1);
    tick;
    branchtaken = 1'b0;
    set_id(1'b0, 5'd0, 6'h00, 5'd0, 5'd0);
    #1;
    chk("br_state3", st3, 0);
    chk("br_flush_off", iff1, 0);

    // memory wait during LDSTALL with cnt = 2
    set_id(1'b1, 5'd5, 6'h00, 5'd5, 5'd7);
    tick;
    set_id(1'b0, 5'd0, 6'h00, 5'd0, 5'd0);
    dmemreq = 1'b1;
    dmemready = 1'b0;
    #1;
    chk("mw_detect_state3", st3, 1);
    chk("mw_detect_freeze3", frz3, 1);
    chk("mw_detect_pcwrite3", pw3, 0);
    chk("mw_detect_bubble3", bub3, 0);
    tick;
    for (int i = 0; i < 3; i++) begin
      chk("mw_wait_state3", st3, 2);
      chk("mw_wait_freeze3", frz3, 1);
      chk("mw_wait_pcwrite3", pw3, 0);
      tick;
    end
    dmemready = 1'b1;
    #1;
    chk("mw_ready_freeze3", frz3, 0);
    chk("mw_ready_pcwrite3", pw3, 0);
    chk("mw_ready_bubble3", bub3, 1);
    chk("mw_ready_freeze1", frz1, 0);
    chk("mw_ready_pcwrite1", pw1, 1);
    tick;
    dmemreq = 1'b0;
    dmemready = 1'b0;
    #1;
    chk("mw_resume_state3_a", st3, 1);
    chk("mw_resume_pcwrite3_a", pw3, 0);
    chk("mw_resume_state1", st1, 0);
    tick;
    chk("mw_resume_state3_b", st3, 1);
    chk("mw_resume_pcwrite3_b", pw3, 0);
    tick;
    chk("mw_resume_state3_c", st3, 0);
    chk("mw_resume_pcwrite3_c", pw3, 1);

    // timeout: 8 MEMWAIT cycles, then one memerr pulse
    dmemreq = 1'b1;
    dmemready = 1'b0;
    #1;
    chk("to_detect_freeze3", frz3, 1);
    tick;
    for (int k = 1; k <= 8; k++) begin
      chk("to_wait_state3", st3, 2);
      chk("to_wait_freeze3", frz3, 1);
      chk("to_wait_memerr3", err3, 0);
      tick;
    end
    dmemreq = 1'b0;
    #1;
    chk("to_memerr3", err3, 1);
    chk("to_state3", st3, 0);
    chk("to_freeze3", frz3, 0);
    chk("to_state1_still_wait", st1, 2);
    tick;
    chk("to_memerr3_pulse_end", err3, 0);

    // reset in the middle of MEMWAIT
    dmemreq = 1'b1;
    #1;
    tick;
    chk("rstmw_state3", st3, 2);
    rst = 1'b1;
    #1;
    chk("rstmw_freeze3", frz3, 0);
    chk("rstmw_pcwrite3", pw3, 0);
    chk("rstmw_bubble3", bub3, 1);
    tick;
    chk("rstmw_state3_after", st3, 0);
    chk("rstmw_state1_after", st1, 0);
    chk("rstmw_memerr3", err3, 0);
    rst = 1'b0;
    dmemreq = 1'b0;
    #1;
    chk("rstmw_rel_pcwrite3", pw3, 1);
    chk("rstmw_rel_freeze3", frz3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
